// File: rtl/pkt_tx_pkg.sv
// Shared constants and the state encoding for the Ethernet/IPv4/UDP transmit deparser.
package pkt_tx_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP     = 8'd17;
    localparam int          HDR_BYTES        = 42;
    localparam int          IPV4_HDR_BYTES   = 20;
    localparam int          UDP_HDR_BYTES    = 8;

    // Fixed IPv4 header halfwords: version/IHL/TOS, identification, DF flag with zero offset
    localparam logic [15:0] IPV4_VER_IHL_TOS = 16'h4500;
    localparam logic [15:0] IPV4_ID          = 16'h0000;
    localparam logic [15:0] IPV4_FLAGS_FRAG  = 16'h4000;
    localparam logic [15:0] UDP_CSUM         = 16'h0000;

    // Header occupies words 0..9; word 10 mixes the last two header bytes with payload
    localparam logic [3:0]  LAST_HDR_WORD    = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_DONE = 2'd3
    } deparse_state_e;

endpackage

// File: rtl/ipv4_csum.sv
// IPv4 header checksum over the ten header halfwords, checksum field taken as zero.
module ipv4_csum (
    input  logic [15:0] total_len_i,
    input  logic [7:0]  ttl_i,
    input  logic [31:0] ip_src_i,
    input  logic [31:0] ip_dst_i,
    output logic [15:0] csum_o
);
    import pkt_tx_pkg::*;

    logic [19:0] sum_w;
    logic [16:0] fold1_w;
    logic [15:0] fold2_w;

    // Ten halfwords never exceed 20 bits; two end-around folds always settle the carry
    always_comb begin
        sum_w = 20'(IPV4_VER_IHL_TOS) + 20'(total_len_i) + 20'(IPV4_ID)
              + 20'(IPV4_FLAGS_FRAG) + 20'({ttl_i, IP_PROTO_UDP})
              + 20'(ip_src_i[31:16]) + 20'(ip_src_i[15:0])
              + 20'(ip_dst_i[31:16]) + 20'(ip_dst_i[15:0]);
        fold1_w = 17'(sum_w[15:0]) + 17'(sum_w[19:16]);
        fold2_w = fold1_w[15:0] + 16'(fold1_w[16]);
        csum_o  = ~fold2_w;
    end

endmodule

// File: rtl/packet_deparser.sv
// Serialises an Ethernet/IPv4/UDP frame onto a 32-bit big-endian word bus.
//
// state | meaning
// IDLE  | waiting for start_i; fields latched on acceptance
// HDR   | emitting header words 0..9, one per cycle
// PAY   | collecting payload bytes; full words pulse out one cycle later
// DONE  | emitting the final (possibly partial) word with last_o
module packet_deparser #(
    parameter int MAX_PAY_LEN = 1472
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start_i,
    input  logic [47:0] eth_dst_i,
    input  logic [47:0] eth_src_i,
    input  logic [31:0] ip_src_i,
    input  logic [31:0] ip_dst_i,
    input  logic [7:0]  ip_ttl_i,
    input  logic [15:0] udp_sport_i,
    input  logic [15:0] udp_dport_i,
    input  logic [15:0] pay_len_i,
    input  logic [7:0]  pay_data_i,
    input  logic        pay_valid_i,
    output logic        pay_ready_o,
    output logic [31:0] bus,
    output logic        start_of_packet_o,
    output logic        valid_o,
    output logic        last_o,
    output logic [1:0]  last_bytes_o,
    output logic        busy_o
);
    import pkt_tx_pkg::*;

    deparse_state_e state_q, state_d;
    logic [3:0]  hdr_idx_q, hdr_idx_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] out_q, out_d;
    logic        out_vld_q, out_vld_d;
    logic [15:0] csum_q;

    logic [47:0] eth_dst_q, eth_src_q;
    logic [31:0] ip_src_q, ip_dst_q;
    logic [7:0]  ttl_q;
    logic [15:0] sport_q, dport_q, len_q;

    logic        accept;
    logic [15:0] len_clamped;
    logic [15:0] total_len;
    logic [15:0] udp_len;
    logic [15:0] csum_c;
    logic [1:0]  lane;
    logic        pay_last;
    logic [31:0] acc_ins;
    logic [31:0] hdr_word;

    assign accept      = (state_q == ST_IDLE) && start_i;
    assign len_clamped = (pay_len_i > 16'(MAX_PAY_LEN)) ? 16'(MAX_PAY_LEN) : pay_len_i;
    assign total_len   = len_q + 16'(IPV4_HDR_BYTES + UDP_HDR_BYTES);
    assign udp_len     = len_q + 16'(UDP_HDR_BYTES);
    // Payload byte n sits at frame byte 42+n, so its lane is offset by two
    assign lane        = pay_cnt_q[1:0] + 2'(HDR_BYTES);
    assign pay_last    = (pay_cnt_q == len_q - 16'd1);

    ipv4_csum u_csum (
        .total_len_i (total_len),
        .ttl_i       (ttl_q),
        .ip_src_i    (ip_src_q),
        .ip_dst_i    (ip_dst_q),
        .csum_o      (csum_c)
    );

    // Latch the packet fields once, on an accepted start
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            eth_dst_q <= '0;
            eth_src_q <= '0;
            ip_src_q  <= '0;
            ip_dst_q  <= '0;
            ttl_q     <= '0;
            sport_q   <= '0;
            dport_q   <= '0;
            len_q     <= '0;
        end else if (accept) begin
            eth_dst_q <= eth_dst_i;
            eth_src_q <= eth_src_i;
            ip_src_q  <= ip_src_i;
            ip_dst_q  <= ip_dst_i;
            ttl_q     <= ip_ttl_i;
            sport_q   <= udp_sport_i;
            dport_q   <= udp_dport_i;
            len_q     <= len_clamped;
        end
    end

    // Checksum is registered during word 0, well ahead of word 6 that carries it
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else if (state_q == ST_HDR && hdr_idx_q == 4'd0) begin
            csum_q <= csum_c;
        end
    end

    // Next-state, payload packing and word hand-off
    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        pay_cnt_d = pay_cnt_q;
        acc_d     = acc_q;
        out_d     = out_q;
        out_vld_d = 1'b0;

        acc_ins = acc_q;
        case (lane)
            2'd0:    acc_ins[31:24] = pay_data_i;
            2'd1:    acc_ins[23:16] = pay_data_i;
            2'd2:    acc_ins[15:8]  = pay_data_i;
            default: acc_ins[7:0]   = pay_data_i;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_HDR;
                    hdr_idx_d = '0;
                    pay_cnt_d = '0;
                    acc_d     = '0;
                    out_d     = '0;
                end
            end
            ST_HDR: begin
                if (hdr_idx_q == LAST_HDR_WORD) begin
                    hdr_idx_d = '0;
                    state_d   = (len_q != 16'd0) ? ST_PAY : ST_DONE;
                end else begin
                    hdr_idx_d = hdr_idx_q + 4'd1;
                end
            end
            ST_PAY: begin
                if (pay_valid_i) begin
                    pay_cnt_d = pay_cnt_q + 16'd1;
                    if (pay_last) begin
                        // Final word goes out in DONE with last_o; unused lanes stay zero
                        out_d   = acc_ins;
                        acc_d   = '0;
                        state_d = ST_DONE;
                    end else if (lane == 2'd3) begin
                        out_d     = acc_ins;
                        out_vld_d = 1'b1;
                        acc_d     = '0;
                    end else begin
                        acc_d = acc_ins;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            hdr_idx_q <= '0;
            pay_cnt_q <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            pay_cnt_q <= pay_cnt_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    // Header word selection; word 10 onward comes from the payload packer
    always_comb begin
        case (hdr_idx_q)
            4'd0:    hdr_word = eth_dst_q[47:16];
            4'd1:    hdr_word = {eth_dst_q[15:0], eth_src_q[47:32]};
            4'd2:    hdr_word = eth_src_q[31:0];
            4'd3:    hdr_word = {ETHERTYPE_IPV4, IPV4_VER_IHL_TOS};
            4'd4:    hdr_word = {total_len, IPV4_ID};
            4'd5:    hdr_word = {IPV4_FLAGS_FRAG, ttl_q, IP_PROTO_UDP};
            4'd6:    hdr_word = {csum_q, ip_src_q[31:16]};
            4'd7:    hdr_word = {ip_src_q[15:0], ip_dst_q[31:16]};
            4'd8:    hdr_word = {ip_dst_q[15:0], sport_q};
            4'd9:    hdr_word = {dport_q, udp_len};
            default: hdr_word = '0;
        endcase
    end

    // Output drive; everything reads zero whenever valid_o is low
    always_comb begin
        bus               = '0;
        start_of_packet_o = 1'b0;
        valid_o           = 1'b0;
        last_o            = 1'b0;
        last_bytes_o      = 2'd0;
        case (state_q)
            ST_HDR: begin
                valid_o           = 1'b1;
                bus               = hdr_word;
                start_of_packet_o = (hdr_idx_q == 4'd0);
            end
            ST_PAY: begin
                valid_o = out_vld_q;
                bus     = out_vld_q ? out_q : 32'd0;
            end
            ST_DONE: begin
                valid_o      = 1'b1;
                bus          = out_q;
                last_o       = 1'b1;
                last_bytes_o = len_q[1:0] + 2'(HDR_BYTES);
            end
            default: begin
                valid_o = 1'b0;
            end
        endcase
    end

    assign pay_ready_o = (state_q == ST_PAY);
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: doc/packet_deparser.md
PACKET_DEPARSER -- requirements
Module: packet_deparser

Interface
REQ-001 SHALL have parameter MAX_PAY_LEN, default 1472, maximum payload bytes per packet.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start_i  input  1  one-cycle request to begin a packet; fields below are sampled in the same cycle.
REQ-005 SHALL have ports eth_dst_i and eth_src_i  input  48 each  Ethernet addresses.
REQ-006 SHALL have ports ip_src_i and ip_dst_i  input  32 each, and ip_ttl_i  input  8.
REQ-007 SHALL have ports udp_sport_i and udp_dport_i  input  16 each, and pay_len_i  input  16  payload bytes.
REQ-008 SHALL have ports pay_data_i  input  8, pay_valid_i  input  1, and pay_ready_o  output  1  payload byte stream; a byte transfers when valid and ready are both high.
REQ-009 SHALL have ports bus  output  32 (big-endian, byte 0 in bits 31:24), start_of_packet_o  output  1, valid_o  output  1, last_o  output  1, last_bytes_o  output  2 (0 means 4 valid bytes), busy_o  output  1.

Function
REQ-010 SHALL emit Ethernet/IPv4/UDP frames: ethertype 0x0800; IPv4 word 0x4500, total_len = 28+pay_len, id 0, flags/frag 0x4000, protocol 17; UDP length = 8+pay_len; UDP checksum 0x0000.
REQ-011 SHALL compute the IPv4 header checksum as the ones-complement of the ones-complement 16-bit sum of the ten header halfwords, with the checksum field taken as 0.
REQ-012 SHALL accept start_i only when busy_o=0, latch all fields, and ignore start_i while busy_o=1.
REQ-013 SHALL clamp pay_len_i values above MAX_PAY_LEN to MAX_PAY_LEN.
REQ-014 SHALL use states IDLE, HDR, PAY and DONE: IDLE to HDR on an accepted start; HDR to PAY after header word 9 when payload remains, otherwise to DONE; PAY to DONE after the last payload byte; DONE to IDLE after one cycle.
REQ-015 SHALL drive header words 0..9 (bytes 0..39) with valid_o=1 on the 10 consecutive cycles after start acceptance, and SHALL assert start_of_packet_o only with word 0.
REQ-016 SHALL form word 10 from header bytes 40..41 followed by payload bytes 0..1, and every later word from 4 consecutive payload bytes.
REQ-017 SHALL hold pay_ready_o high in PAY while payload bytes remain, and low in all other states.
REQ-018 SHALL pulse valid_o for one cycle when a word has 4 bytes or holds the final byte, and SHALL keep valid_o=0 while waiting for pay_valid_i.
REQ-019 SHALL make the total word count ceil((42+pay_len)/4), assert last_o with the final word, set last_bytes_o=(42+pay_len) mod 4, and zero the unused low bytes.
REQ-020 SHALL treat pay_len=0 as a 42-byte frame: 11 words, last word = bytes 40..41 then 0x0000, last_bytes_o=2.
REQ-021 SHALL hold busy_o high from the cycle after start acceptance through DONE.
REQ-022 SHALL drive bus and last_bytes_o to zero in any cycle where valid_o=0.

Reset
REQ-023 SHALL, on reset assertion (including mid-packet), immediately force IDLE and drive bus, start_of_packet_o, valid_o, last_o, last_bytes_o, pay_ready_o and busy_o to 0, discarding any partial packet.
REQ-024 SHALL accept start_i in the first cycle after reset deasserts.

Structure
REQ-025 SHALL place the state enum and the constants ETHERTYPE_IPV4, IP_PROTO_UDP, HDR_BYTES=42, IPV4_HDR_BYTES=20 and UDP_HDR_BYTES=8 in a shared package pkt_tx_pkg.
REQ-026 SHALL implement the checksum in one sub-module ipv4_csum, combinational from the latched fields and registered once before word 6 is emitted.

Verification
REQ-027 SHALL cover: ip_src C0A80001, ip_dst C0A800C7, ttl 0x40, pay_len 87 -> total_len 0x0073, checksum 0xB861, 33 words, last_bytes_o=1.
REQ-028 SHALL cover: pay_len 2 with pay_valid held high -> 11 words, word 10 = header bytes 40..41 followed by both payload bytes, last_o on word 10, last_bytes_o=0.
REQ-029 SHALL cover: pay_len 0 -> 11 words, pay_ready_o never asserted, last word low half 0x0000, last_bytes_o=2.
REQ-030 SHALL cover: pay_len 11 with pay_valid low for 5 cycles after byte 3 -> valid_o stays low during the stall, 14 words, byte order intact, last_bytes_o=1.
REQ-031 SHALL cover: start_i pulsed at header word 4, then reset asserted at payload byte 6 -> the second start is ignored; all outputs read 0 during reset; a new packet after reset is bit-exact against the parser model.
